// File: rtl/cpu_mc_pkg.sv
// cpu_mc_pkg: state, decode-field, ALU-op and branch-condition constants for the
// multi-cycle core, plus the instruction layout and immediate helpers.
package cpu_mc_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_STORE = 3'd4
  } state_e;

  // Instruction form, ir[31:30]
  localparam logic [1:0] FORM_RI  = 2'b00;
  localparam logic [1:0] FORM_RR  = 2'b01;
  localparam logic [1:0] FORM_BR  = 2'b10;
  localparam logic [1:0] FORM_ILL = 2'b11;

  // Instruction class, ir[29:28]
  localparam logic [1:0] CLS_ALU   = 2'b00;
  localparam logic [1:0] CLS_LOAD  = 2'b01;
  localparam logic [1:0] CLS_STORE = 2'b10;
  localparam logic [1:0] CLS_ALU2  = 2'b11;

  // ALU operation codes; 10..15 produce zero
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SHL  = 4'd5;
  localparam logic [3:0] ALU_SHR  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  // Branch condition, ir[23:22]
  localparam logic [1:0] BR_ALW0 = 2'b00;
  localparam logic [1:0] BR_ALW1 = 2'b01;
  localparam logic [1:0] BR_EQZ  = 2'b10;
  localparam logic [1:0] BR_NEZ  = 2'b11;

  // Link register indices (before truncation to the register-file width)
  localparam logic [3:0] REG_LINK = 4'd15;
  localparam logic [3:0] REG_TRAP = 4'd14;

  typedef struct packed {
    logic [1:0]  form;
    logic [1:0]  cls;
    logic [3:0]  rd;
    logic [3:0]  aluop;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [11:0] lo;
  } instr_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext22(input logic [21:0] v);
    return {{10{v[21]}}, v};
  endfunction

endpackage

// File: rtl/cpu_mc_alu.sv
// cpu_mc_alu: combinational 32-bit ALU; shift amount is b[4:0], arithmetic wraps.
module cpu_mc_alu
  import cpu_mc_pkg::*;
(
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] res_c_o
);

  logic [4:0] sh;
  assign sh = b_i[4:0];

  // Operation select; undefined codes yield zero
  always_comb begin
    res_c_o = '0;
    case (op_i)
      ALU_ADD:  res_c_o = a_i + b_i;
      ALU_SUB:  res_c_o = a_i - b_i;
      ALU_AND:  res_c_o = a_i & b_i;
      ALU_OR:   res_c_o = a_i | b_i;
      ALU_XOR:  res_c_o = a_i ^ b_i;
      ALU_SHL:  res_c_o = a_i << sh;
      ALU_SHR:  res_c_o = a_i >> sh;
      ALU_SRA:  res_c_o = XLEN'($signed(a_i) >>> sh);
      ALU_SLT:  res_c_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: res_c_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      default:  res_c_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle 32-bit core (RESET/FETCH/EXEC/LOAD/STORE) with a single
// request/ack memory port. Define CPU_MC_TRAP_EN to make form 11 trap to
// TRAP_VECTOR with the return byte address in r14; otherwise form 11 is a no-op.
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int unsigned ADDR_W      = 30,
  parameter int unsigned REG_LOG2    = 4,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned TRAP_VECTOR = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] dbg_pc,
  output logic              retire
);

  localparam int unsigned NREG = 1 << REG_LOG2;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  instr_t              ir_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [XLEN-1:0]     mem_wdata_q;
  logic [XLEN-1:0]     rf_q [NREG];

  logic [REG_LOG2-1:0] rd_idx, ra_idx, rb_idx;
  logic [XLEN-1:0]     rd_val, ra_val, rb_val, opb, alu_y, ls_sum, link, br_full;
  logic [ADDR_W-1:0]   pc_inc, br_tgt, exec_pc;
  logic                is_mem_form, is_load, is_store, br_taken;
  logic                rf_we;
  logic [REG_LOG2-1:0] rf_waddr;
  logic [XLEN-1:0]     rf_wdata;
  logic                unused_bits;

  // Decode and register reads; r0 always reads as zero
  assign rd_idx = REG_LOG2'(ir_q.rd);
  assign ra_idx = REG_LOG2'(ir_q.ra);
  assign rb_idx = REG_LOG2'(ir_q.rb);
  assign rd_val = (rd_idx == '0) ? '0 : rf_q[rd_idx];
  assign ra_val = (ra_idx == '0) ? '0 : rf_q[ra_idx];
  assign rb_val = (rb_idx == '0) ? '0 : rf_q[rb_idx];
  assign opb    = (ir_q.form == FORM_RI) ? sext16(ir_q[15:0]) : rb_val;

  assign is_mem_form = (ir_q.form == FORM_RI) || (ir_q.form == FORM_RR);
  assign is_load     = is_mem_form && (ir_q.cls == CLS_LOAD);
  assign is_store    = is_mem_form && (ir_q.cls == CLS_STORE);

  cpu_mc_alu u_alu (
    .op_i    (ir_q.aluop),
    .a_i     (ra_val),
    .b_i     (opb),
    .res_c_o (alu_y)
  );

  // Address arithmetic: load/store byte address, pc+1, its byte address, branch target
  assign ls_sum  = ra_val + opb;
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign link    = XLEN'({pc_inc, 2'b00});
  assign br_full = XLEN'(pc_q) + XLEN'(1) + sext22(ir_q[21:0]);
  assign br_tgt  = br_full[ADDR_W-1:0];

  // Only part of the address sums is architecturally visible
  assign unused_bits = ^{ls_sum, br_full};

  // Branch condition on the value of register rd
  always_comb begin
    br_taken = 1'b0;
    case (ir_q.aluop[3:2])
      BR_ALW0, BR_ALW1: br_taken = 1'b1;
      BR_EQZ:           br_taken = (rd_val == '0);
      BR_NEZ:           br_taken = (rd_val != '0);
      default:          br_taken = 1'b0;
    endcase
  end

  // Next fetch address after a non-memory instruction completes in EXEC
  always_comb begin
    exec_pc = pc_inc;
    if ((ir_q.form == FORM_BR) && br_taken) exec_pc = br_tgt;
`ifdef CPU_MC_TRAP_EN
    if (ir_q.form == FORM_ILL) exec_pc = ADDR_W'(TRAP_VECTOR);
`endif
  end

  // Single register write port: ALU result, link, trap link, or load data
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rd_idx;
    rf_wdata = alu_y;
    if (!rst) begin
      case (state_q)
        ST_EXEC: begin
          case (ir_q.form)
            FORM_RI, FORM_RR: rf_we = !is_load && !is_store;
            FORM_BR: begin
              if (ir_q.cls[0]) begin
                rf_we    = 1'b1;
                rf_waddr = REG_LOG2'(REG_LINK);
                rf_wdata = link;
              end
            end
`ifdef CPU_MC_TRAP_EN
            FORM_ILL: begin
              rf_we    = 1'b1;
              rf_waddr = REG_LOG2'(REG_TRAP);
              rf_wdata = link;
            end
`endif
            default: ;
          endcase
        end
        ST_LOAD: begin
          if (mem_ack) begin
            rf_we    = 1'b1;
            rf_wdata = mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Register file storage; writes to r0 are dropped
  always_ff @(posedge clk) begin
    if (rf_we && (rf_waddr != '0)) rf_q[rf_waddr] <= rf_wdata;
  end

  // Control FSM with registered memory-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESET;
      pc_q        <= ADDR_W'(RESET_PC);
      ir_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= ADDR_W'(RESET_PC);
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          state_q    <= ST_FETCH;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= pc_q;
        end
        ST_FETCH: begin
          if (mem_ack) begin
            ir_q      <= mem_rdata;
            state_q   <= ST_EXEC;
            mem_req_q <= 1'b0;
          end
        end
        ST_EXEC: begin
          mem_req_q <= 1'b1;
          if (is_load || is_store) begin
            state_q     <= is_load ? ST_LOAD : ST_STORE;
            mem_we_q    <= is_store;
            mem_addr_q  <= ls_sum[ADDR_W+1:2];
            mem_wdata_q <= rd_val;
          end else begin
            state_q    <= ST_FETCH;
            mem_we_q   <= 1'b0;
            pc_q       <= exec_pc;
            mem_addr_q <= exec_pc;
          end
        end
        ST_LOAD, ST_STORE: begin
          if (mem_ack) begin
            state_q    <= ST_FETCH;
            mem_we_q   <= 1'b0;
            pc_q       <= pc_inc;
            mem_addr_q <= pc_inc;
          end
        end
        default: begin
          state_q   <= ST_RESET;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_pc    = pc_q;

  // Completion strobe: end of EXEC for non-memory ops, ack cycle for load/store
  assign retire = !rst &&
                  (((state_q == ST_EXEC) && !is_load && !is_store) ||
                   (((state_q == ST_LOAD) || (state_q == ST_STORE)) && mem_ack));

endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: directed bench for cpu_mc. The bench acts as memory; every expected
// bus transaction is queued before it is served and compared when the core issues it.
module tb_cpu_mc;
  localparam int unsigned AW = 30;

  logic          clk, rst;
  logic          mem_req, mem_we, mem_ack, retire;
  logic [AW-1:0] mem_addr, dbg_pc;
  logic [31:0]   mem_wdata, mem_rdata;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [AW-1:0] pc;
  } txn_t;

  txn_t sb[$];
  int   ret_q[$];
  int   cyc;
  int   checks   = 0;
  int   failures = 0;

  cpu_mc dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .dbg_pc    (dbg_pc),
    .retire    (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number since reset release (cycle 1 = first FETCH cycle)
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Log the cycle number of each retire pulse, sampled mid-cycle
  always @(negedge clk) begin
    #2;
    if (rst === 1'b0 && retire === 1'b1) ret_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for a request, compare it with the head of the scoreboard, hold for
  // 'waits' cycles checking stability, then acknowledge with rdata.
  task automatic serve(input string tag, input int waits, input logic [31:0] rdata);
    txn_t e;
    int   n;
    n = 0;
    while (mem_req !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_seen"}, 32'(mem_req), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int i = 0; i <= waits; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("%s_req_w%0d", tag, i), 32'(mem_req), 32'd1);
      chk($sformatf("%s_we_w%0d", tag, i), 32'(mem_we), 32'(e.we));
      chk($sformatf("%s_addr_w%0d", tag, i), 32'(mem_addr), 32'(e.addr));
      chk($sformatf("%s_pc_w%0d", tag, i), 32'(dbg_pc), 32'(e.pc));
      if (e.we) chk($sformatf("%s_wdata_w%0d", tag, i), mem_wdata, e.wdata);
      if (i < waits) chk($sformatf("%s_noretire_w%0d", tag, i), 32'(retire), 32'd0);
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [31:0] instr);
    sb.push_back('{we: 1'b0, addr: a, wdata: 32'h0, pc: a});
    serve($sformatf("fetch@%0h", a), 0, instr);
  endtask

  task automatic load(input logic [AW-1:0] pc, input logic [AW-1:0] a,
                      input logic [31:0] d, input int waits);
    sb.push_back('{we: 1'b0, addr: a, wdata: 32'h0, pc: pc});
    serve($sformatf("load@%0h", a), waits, d);
  endtask

  task automatic store(input logic [AW-1:0] pc, input logic [AW-1:0] a,
                       input logic [31:0] d, input int waits);
    sb.push_back('{we: 1'b1, addr: a, wdata: d, pc: pc});
    serve($sformatf("store@%0h", a), waits, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] p;
    int            n;
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    // Reset: held three cycles
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_pc", 32'(dbg_pc), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", 32'(mem_addr), 32'd0);
    chk("first_we", 32'(mem_we), 32'd0);
    ret_q.delete();

    // Zero-wait: r1 = r0 + 5, then load r2 = mem[r1 + 3] (word 2)
    fetch(30'd0, 32'h01000005);
    fetch(30'd1, 32'h12010003);
    load(30'd1, 30'd2, 32'hDEADBEEF, 0);
    chk("retire_count", 32'(ret_q.size()), 32'd2);
    chk("retire_cyc_a", 32'((ret_q.size() > 0) ? ret_q[0] : -1), 32'd2);
    chk("retire_cyc_b", 32'((ret_q.size() > 1) ? ret_q[1] : -1), 32'd5);

    // Store r2 to word 0x10 with three wait states
    fetch(30'd2, 32'h22000040);
    store(30'd2, 30'h10, 32'hDEADBEEF, 3);

    // r3 = r2 - r1 (register form)
    fetch(30'd3, 32'h43121000);
    // Branch to self, then branch-and-link to self (r15 = 0x14)
    fetch(30'd4, 32'h803FFFFF);
    fetch(30'd4, 32'h903FFFFF);
    fetch(30'd4, 32'h2F000044);
    store(30'd4, 30'h11, 32'h00000014, 0);
    fetch(30'd5, 32'h23000048);
    store(30'd5, 30'h12, 32'hDEADBEEA, 0);

    // Illegal form at word 6
    fetch(30'd6, 32'hC0000000);
`ifdef CPU_MC_TRAP_EN
    fetch(30'd1, 32'h2E00004C);
    store(30'd1, 30'h13, 32'h0000001C, 0);
    p = 30'd2;
`else
    p = 30'd7;
`endif

    // ALU patterns: shl, sra, slt, sltu, r0 write, class-11 ALU
    fetch(p + 30'd0,  32'h04510003);
    fetch(p + 30'd1,  32'h45731000);
    fetch(p + 30'd2,  32'h46831000);
    fetch(p + 30'd3,  32'h47931000);
    fetch(p + 30'd4,  32'h00000007);
    fetch(p + 30'd5,  32'h39000003);
    fetch(p + 30'd6,  32'h24000050);
    store(p + 30'd6,  30'h14, 32'h00000028, 0);
    fetch(p + 30'd7,  32'h25000054);
    store(p + 30'd7,  30'h15, 32'hFEF56DF7, 0);
    fetch(p + 30'd8,  32'h26000058);
    store(p + 30'd8,  30'h16, 32'h00000001, 0);
    fetch(p + 30'd9,  32'h2700005C);
    store(p + 30'd9,  30'h17, 32'h00000000, 1);
    fetch(p + 30'd10, 32'h20000060);
    store(p + 30'd10, 30'h18, 32'h00000000, 0);
    fetch(p + 30'd11, 32'h29000064);
    store(p + 30'd11, 30'h19, 32'h00000003, 0);

    // Conditional branches on r1 = 5: bnz taken (+2), bz not taken
    fetch(p + 30'd12, 32'h81C00002);
    fetch(p + 30'd15, 32'h81800002);

    // Register-form load/store at byte 45 (low bits ignored -> word 11)
    fetch(p + 30'd16, 32'h58014000);
    load(p + 30'd16, 30'd11, 32'h12345678, 2);
    fetch(p + 30'd17, 32'h68014000);
    store(p + 30'd17, 30'd11, 32'h12345678, 0);

    // Reset during load wait: ack arrives with rst high and must be dropped
    fetch(p + 30'd18, 32'h12010003);
    n = 0;
    while (mem_req !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("abort_load_req", 32'(mem_req), 32'd1);
    chk("abort_load_addr", 32'(mem_addr), 32'd2);
    @(negedge clk);
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk("abort_req_low", 32'(mem_req), 32'd0);
    chk("abort_pc", 32'(dbg_pc), 32'd0);
    chk("abort_retire", 32'(retire), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fetch(30'd0, 32'h22000040);
    store(30'd0, 30'h10, 32'hDEADBEEF, 0);

    // pc wrap: branch to the last word, then sequential fetch wraps to 0
    fetch(30'd1, 32'h803FFFFD);
    fetch(30'h3FFFFFFF, 32'h00000000);
    fetch(30'd0, 32'h00000000);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
